// File: rtl/mul_issue_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : mul_issue_arbiter
// Purpose  : Round-robin issue of NUM_REQ multiply reservation slots onto one
//            fixed-latency 32x32 multiplier. Holds the selected product half
//            on the CDB until it is accepted.
// Options  : MUL_ARB_BACK_TO_BACK_EN - when defined, a new grant may be issued
//            in the RESP cycle that completes the CDB handshake (RESP->RUN).
// Revision : 1.0 - initial release
// ============================================================================
module mul_issue_arbiter #(
    parameter int NUM_REQ     = 4,
    parameter int MUL_LATENCY = 4,
    parameter int TAG_W       = 6
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       flush,
    input  logic [NUM_REQ-1:0]         req_valid,
    input  logic [NUM_REQ*32-1:0]      req_a,
    input  logic [NUM_REQ*32-1:0]      req_b,
    input  logic [NUM_REQ*2-1:0]       req_mul_type,
    input  logic [NUM_REQ-1:0]         req_high,
    input  logic [NUM_REQ*TAG_W-1:0]   req_tag,
    output logic [NUM_REQ-1:0]         req_grant,
    output logic                       mul_start,
    output logic [31:0]                mul_a,
    output logic [31:0]                mul_b,
    output logic [1:0]                 mul_type,
    input  logic [63:0]                mul_product,
    output logic                       cdb_valid,
    input  logic                       cdb_ready,
    output logic [31:0]                cdb_data,
    output logic [TAG_W-1:0]           cdb_tag,
    output logic                       busy
);

    localparam int PTR_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam int CNT_W = $clog2(MUL_LATENCY + 1);
    localparam logic [PTR_W-1:0] LAST_IDX = PTR_W'(NUM_REQ - 1);
    localparam logic [CNT_W-1:0] CNT_INIT = CNT_W'(MUL_LATENCY);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(1);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_RESP = 2'd2
    } state_t;

    state_t             r_state;
    logic [PTR_W-1:0]   r_rr_ptr;
    logic [CNT_W-1:0]   r_cnt;
    logic               r_mul_start;
    logic [31:0]        r_mul_a;
    logic [31:0]        r_mul_b;
    logic [1:0]         r_mul_type;
    logic               r_high;
    logic [TAG_W-1:0]   r_tag;
    logic               r_cdb_valid;
    logic [31:0]        r_cdb_data;
    logic [TAG_W-1:0]   r_cdb_tag;

    logic               w_arb_en;
    logic               w_found;
    logic [PTR_W-1:0]   w_gidx;
    logic [PTR_W-1:0]   w_idx;
    logic [PTR_W-1:0]   w_next_ptr;
    logic               w_grant_en;
    logic [NUM_REQ-1:0] w_grant;
    int                 w_scan;

    // Arbitration window: IDLE, or optionally the accepting RESP cycle; flush and reset block it
    always_comb begin
        w_arb_en = 1'b0;
        if (rst_n && !flush) begin
            if (r_state == ST_IDLE) begin
                w_arb_en = 1'b1;
            end
`ifdef MUL_ARB_BACK_TO_BACK_EN
            if (r_state == ST_RESP && cdb_ready) begin
                w_arb_en = 1'b1;
            end
`else
            // Without back-to-back issue the RESP cycle never arbitrates
`endif
        end
    end

    // Round-robin pick: first requesting slot at or above rr_ptr, wrapping around
    always_comb begin
        w_found = 1'b0;
        w_gidx  = '0;
        w_idx   = '0;
        w_scan  = 0;
        for (int k = 0; k < NUM_REQ; k++) begin
            w_scan = int'(r_rr_ptr) + k;
            if (w_scan >= NUM_REQ) begin
                w_scan = w_scan - NUM_REQ;
            end
            w_idx = PTR_W'(w_scan);
            if (!w_found && req_valid[w_idx]) begin
                w_found = 1'b1;
                w_gidx  = w_idx;
            end
        end
    end

    // One-hot grant and the pointer that follows the granted slot
    always_comb begin
        w_grant_en = w_arb_en & w_found;
        w_grant    = '0;
        if (w_grant_en) begin
            w_grant[w_gidx] = 1'b1;
        end
        w_next_ptr = (w_gidx == LAST_IDX) ? '0 : w_gidx + PTR_W'(1);
    end

    // Transaction FSM: latch on grant, count latency, capture result, hold on CDB
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= ST_IDLE;
            r_rr_ptr    <= '0;
            r_cnt       <= '0;
            r_mul_start <= 1'b0;
            r_mul_a     <= '0;
            r_mul_b     <= '0;
            r_mul_type  <= '0;
            r_high      <= 1'b0;
            r_tag       <= '0;
            r_cdb_valid <= 1'b0;
            r_cdb_data  <= '0;
            r_cdb_tag   <= '0;
        end else if (flush) begin
            // In-flight work is dropped; the round-robin pointer survives
            r_state     <= ST_IDLE;
            r_cnt       <= '0;
            r_mul_start <= 1'b0;
            r_cdb_valid <= 1'b0;
        end else if (w_grant_en) begin
            r_mul_a     <= req_a[32*w_gidx +: 32];
            r_mul_b     <= req_b[32*w_gidx +: 32];
            r_mul_type  <= req_mul_type[2*w_gidx +: 2];
            r_high      <= req_high[w_gidx];
            r_tag       <= req_tag[TAG_W*w_gidx +: TAG_W];
            r_rr_ptr    <= w_next_ptr;
            r_cnt       <= CNT_INIT;
            r_mul_start <= 1'b1;
            r_cdb_valid <= 1'b0;
            r_state     <= ST_RUN;
        end else begin
            r_mul_start <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    r_state <= ST_IDLE;
                end
                ST_RUN: begin
                    // Product is valid in the cycle the counter reaches one
                    if (r_cnt == CNT_LAST) begin
                        r_cdb_data  <= r_high ? mul_product[63:32] : mul_product[31:0];
                        r_cdb_tag   <= r_tag;
                        r_cdb_valid <= 1'b1;
                        r_cnt       <= '0;
                        r_state     <= ST_RESP;
                    end else begin
                        r_cnt <= r_cnt - CNT_W'(1);
                    end
                end
                ST_RESP: begin
                    if (cdb_ready) begin
                        r_cdb_valid <= 1'b0;
                        r_state     <= ST_IDLE;
                    end
                end
                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    assign req_grant = w_grant;
    assign mul_start = r_mul_start;
    assign mul_a     = r_mul_a;
    assign mul_b     = r_mul_b;
    assign mul_type  = r_mul_type;
    assign cdb_valid = r_cdb_valid;
    assign cdb_data  = r_cdb_data;
    assign cdb_tag   = r_cdb_tag;
    assign busy      = (r_state != ST_IDLE);

endmodule
`default_nettype wire

// File: tb/tb_mul_issue_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_mul_issue_arbiter
// Purpose  : Self-checking bench for mul_issue_arbiter. A transaction-level
//            reference (pending slots, round-robin pointer, grant timestamp)
//            predicts grant, start pulse, busy and CDB outputs every cycle.
//            The bench also plays the fixed-latency multiplier.
// Options  : honours MUL_ARB_BACK_TO_BACK_EN in the reference model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_mul_issue_arbiter;

    localparam int N  = 4;
    localparam int L  = 4;
    localparam int TW = 6;

    logic            clk;
    logic            rst_n;
    logic            flush;
    logic [N-1:0]    req_valid;
    logic [N*32-1:0] req_a;
    logic [N*32-1:0] req_b;
    logic [N*2-1:0]  req_mul_type;
    logic [N-1:0]    req_high;
    logic [N*TW-1:0] req_tag;
    logic [N-1:0]    req_grant;
    logic            mul_start;
    logic [31:0]     mul_a;
    logic [31:0]     mul_b;
    logic [1:0]      mul_type;
    logic [63:0]     mul_product;
    logic            cdb_valid;
    logic            cdb_ready;
    logic [31:0]     cdb_data;
    logic [TW-1:0]   cdb_tag;
    logic            busy;

    mul_issue_arbiter #(.NUM_REQ(N), .MUL_LATENCY(L), .TAG_W(TW)) dut (
        .clk(clk), .rst_n(rst_n), .flush(flush),
        .req_valid(req_valid), .req_a(req_a), .req_b(req_b),
        .req_mul_type(req_mul_type), .req_high(req_high), .req_tag(req_tag),
        .req_grant(req_grant), .mul_start(mul_start), .mul_a(mul_a),
        .mul_b(mul_b), .mul_type(mul_type), .mul_product(mul_product),
        .cdb_valid(cdb_valid), .cdb_ready(cdb_ready), .cdb_data(cdb_data),
        .cdb_tag(cdb_tag), .busy(busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // requester slots
    bit          pend [N];
    logic [31:0] s_a  [N];
    logic [31:0] s_b  [N];
    logic [1:0]  s_t  [N];
    logic        s_h  [N];
    logic [TW-1:0] s_tag [N];
    int          refill_pct;

    // reference model
    int          m_ptr;
    bit          m_run;
    bit          m_resp;
    int          m_gcyc;
    logic [31:0] m_data;
    logic [TW-1:0] m_tag;
    int          mult_ready_cyc;

    int          cyc;
    int          n_checks;
    int          n_pass;
    logic [N-1:0] obs_grant;
    int          last_g;
    int          t0;
    int          gq[$];

    task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h (cycle %0d)", name, got, exp, cyc);
    endtask

    function automatic logic [63:0] ref_mul(input logic [31:0] a, input logic [31:0] b, input logic [1:0] t);
        logic [63:0] xa;
        logic [63:0] xb;
        xa = {{32{a[31] & (t == 2'b01 || t == 2'b10)}}, a};
        xb = {{32{b[31] & (t == 2'b01)}}, b};
        return xa * xb;
    endfunction

    function automatic logic [31:0] pick_operand();
        case ($urandom_range(0, 5))
            0: return 32'h0000_0000;
            1: return 32'h0000_0001;
            2: return 32'hFFFF_FFFF;
            3: return 32'h8000_0000;
            4: return 32'h7FFF_FFFF;
            default: return $urandom;
        endcase
    endfunction

    task automatic set_req(input int i, input logic [31:0] a, input logic [31:0] b,
                           input logic [1:0] t, input logic h, input logic [TW-1:0] tag);
        s_a[i] = a; s_b[i] = b; s_t[i] = t; s_h[i] = h; s_tag[i] = tag; pend[i] = 1'b1;
    endtask

    // One clock cycle: entered at posedge+1, drive, check at posedge+3, update model, advance.
    task automatic run_cycle();
        logic [N-1:0] exp_grant;
        logic [63:0]  p;
        bit           free;
        int           g;
        int           idx;
        for (int i = 0; i < N; i++) begin
            if (!pend[i] && refill_pct > 0 && $urandom_range(0, 99) < refill_pct)
                set_req(i, pick_operand(), pick_operand(), 2'($urandom_range(0, 2)),
                        1'($urandom_range(0, 1)), TW'($urandom));
            req_valid[i]          = pend[i];
            req_a[32*i +: 32]     = s_a[i];
            req_b[32*i +: 32]     = s_b[i];
            req_mul_type[2*i +: 2] = s_t[i];
            req_high[i]           = s_h[i];
            req_tag[TW*i +: TW]   = s_tag[i];
        end
        mul_product = (cyc == mult_ready_cyc) ? ref_mul(mul_a, mul_b, mul_type)
                                              : 64'hBADC_0FFE_E0DD_F00D;
        #2;
        free = !m_run && !m_resp;
`ifdef MUL_ARB_BACK_TO_BACK_EN
        if (m_resp && cdb_ready) free = 1'b1;
`endif
        g = -1;
        if (free && !flush) begin
            for (int k = 0; k < N; k++) begin
                idx = (m_ptr + k) % N;
                if (g < 0 && pend[idx]) g = idx;
            end
        end
        exp_grant = '0;
        if (g >= 0) exp_grant[g] = 1'b1;
        obs_grant = req_grant;
        last_g    = g;
        check("grant", 64'(req_grant), 64'(exp_grant));
        check("cdb_valid", 64'(cdb_valid), 64'(m_resp));
        if (m_resp) begin
            check("cdb_data", 64'(cdb_data), 64'(m_data));
            check("cdb_tag", 64'(cdb_tag), 64'(m_tag));
        end
        check("busy", 64'(busy), 64'(m_run || m_resp));
        check("mul_start", 64'(mul_start), 64'(m_run && cyc == m_gcyc + 1));
        if (mul_start) mult_ready_cyc = cyc + L - 1;
        if (obs_grant != '0)
            for (int i = 0; i < N; i++) if (obs_grant[i]) gq.push_back(i);
        if (flush) begin
            m_run = 0; m_resp = 0;
        end else begin
            if (m_resp && cdb_ready) m_resp = 0;
            if (m_run && cyc == m_gcyc + L) begin m_run = 0; m_resp = 1; end
            if (g >= 0) begin
                p      = ref_mul(s_a[g], s_b[g], s_t[g]);
                m_data = s_h[g] ? p[63:32] : p[31:0];
                m_tag  = s_tag[g];
                m_gcyc = cyc;
                m_ptr  = (g + 1) % N;
                m_run  = 1;
                pend[g] = 1'b0;
            end
        end
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic drain();
        int n;
        refill_pct = 0; cdb_ready = 1'b1; flush = 1'b0;
        n = 0;
        while ((m_run || m_resp || pend[0] || pend[1] || pend[2] || pend[3]) && n < 200) begin
            run_cycle(); n++;
        end
        check("drain_timeout", 64'(n < 200), 64'd1);
    endtask

    task automatic wait_resp();
        int n;
        n = 0;
        while (!m_resp && n < 50) begin run_cycle(); n++; end
        check("resp_timeout", 64'(m_resp), 64'd1);
    endtask

    task automatic check_all_zero(input string pfx);
        check({pfx, "_grant"}, 64'(req_grant), 64'd0);
        check({pfx, "_mul_start"}, 64'(mul_start), 64'd0);
        check({pfx, "_mul_a"}, 64'(mul_a), 64'd0);
        check({pfx, "_mul_b"}, 64'(mul_b), 64'd0);
        check({pfx, "_mul_type"}, 64'(mul_type), 64'd0);
        check({pfx, "_cdb_valid"}, 64'(cdb_valid), 64'd0);
        check({pfx, "_cdb_data"}, 64'(cdb_data), 64'd0);
        check({pfx, "_cdb_tag"}, 64'(cdb_tag), 64'd0);
        check({pfx, "_busy"}, 64'(busy), 64'd0);
    endtask

    initial begin
        n_checks = 0; n_pass = 0; cyc = 0;
        m_ptr = 0; m_run = 0; m_resp = 0; m_gcyc = -100; mult_ready_cyc = -1;
        refill_pct = 0;
        for (int i = 0; i < N; i++) set_req(i, 0, 0, 2'b00, 1'b0, '0);
        for (int i = 0; i < N; i++) pend[i] = 1'b0;
        rst_n = 1'b0; flush = 1'b0; cdb_ready = 1'b1;
        req_valid = '0; req_a = '0; req_b = '0; req_mul_type = '0;
        req_high = '0; req_tag = '0; mul_product = '0;

        // reset state
        #3;
        check_all_zero("reset");
        @(posedge clk); @(posedge clk); #1;
        rst_n = 1'b1;

        // round-robin fairness with all slots requesting continuously
        for (int i = 0; i < N; i++)
            set_req(i, pick_operand(), pick_operand(), 2'($urandom_range(0, 2)), 1'b0, TW'(i));
        refill_pct = 100;
        gq.delete();
        for (int n = 0; n < 80 && gq.size() < 5; n++) run_cycle();
        check("rr_count", 64'(gq.size() >= 5), 64'd1);
        if (gq.size() >= 5)
            for (int k = 0; k < 5; k++) check("rr_order", 64'(gq[k]), 64'(k % N));
        drain();

        // single signed multiply on slot 2: -2 * 3 = -6
        set_req(2, 32'hFFFF_FFFE, 32'd3, 2'b01, 1'b0, TW'(5));
        run_cycle();
        check("sgn_grant", 64'(obs_grant), 64'b0100);
        t0 = cyc - 1;
        wait_resp();
        #1;
        check("sgn_latency", 64'(cyc - t0), 64'(L + 1));
        check("sgn_data", 64'(cdb_data), 64'hFFFF_FFFA);
        check("sgn_tag", 64'(cdb_tag), 64'd5);
        drain();

        // unsigned high half of 0xFFFFFFFF squared
        set_req(0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 2'b00, 1'b1, TW'(17));
        wait_resp();
        #1;
        check("hi_data", 64'(cdb_data), 64'hFFFF_FFFE);
        drain();

        // backpressure: result held ten cycles while another slot waits
        cdb_ready = 1'b0;
        set_req(1, $urandom, $urandom, 2'b10, 1'b1, TW'(33));
        wait_resp();
        set_req(3, $urandom, $urandom, 2'b01, 1'b0, TW'(34));
        for (int k = 0; k < 10; k++) run_cycle();
        cdb_ready = 1'b1;
        run_cycle();
        drain();

        // flush two cycles after a grant
        set_req(2, 32'd7, 32'd9, 2'b00, 1'b0, TW'(9));
        run_cycle();
        run_cycle();
        flush = 1'b1;
        run_cycle();
        flush = 1'b0;
        #1;
        check("flush_idle", 64'(busy), 64'd0);
        set_req(0, $urandom, $urandom, 2'b00, 1'b0, TW'(40));
        set_req(3, $urandom, $urandom, 2'b00, 1'b0, TW'(41));
        run_cycle();
        check("flush_next_grant", 64'(obs_grant), 64'b1000);
        drain();

        // randomized traffic with backpressure and occasional flush
        refill_pct = 40;
        for (int k = 0; k < 400; k++) begin
            cdb_ready = ($urandom_range(0, 99) < 70);
            flush     = ($urandom_range(0, 99) < 3);
            run_cycle();
        end
        drain();

        // asynchronous reset while holding a result in RESP
        cdb_ready = 1'b0;
        set_req(1, $urandom, $urandom, 2'b01, 1'b1, TW'(50));
        wait_resp();
        #1;
        rst_n = 1'b0;
        #1;
        check_all_zero("async_rst");
        @(posedge clk); #1;
        rst_n = 1'b1;
        cyc++;
        m_ptr = 0; m_run = 0; m_resp = 0; mult_ready_cyc = -1;
        cdb_ready = 1'b1;
        set_req(3, $urandom, $urandom, 2'b00, 1'b0, TW'(51));
        set_req(0, $urandom, $urandom, 2'b00, 1'b0, TW'(52));
        run_cycle();
        check("rst_first_grant", 64'(obs_grant), 64'b0001);
        drain();

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    // hard stop in case a wait never returns
    initial begin
        #200000;
        $display("FAIL global_timeout: got running expected finished");
        $fatal(1);
    end

endmodule
`default_nettype wire
